// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute-stage hazard logic and muldiv_unit.
interface muldiv_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (output start, op, src_a, src_b, flush, input busy, done, result);
  modport slave  (input start, op, src_a, src_b, flush, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide on magnitudes.
// MULDIV_FAST_MUL_EN: multiplies use a combinational multiplier and skip the iteration.
module muldiv_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic [DW-1:0]        opnd_q, opnd_d;
  logic [DW-1:0]        hi_q, hi_d;
  logic [DW-1:0]        lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DW-1:0]        result_q, result_d;

  logic          accept_c, direct_c, is_div_in, a_signed, b_signed;
  logic          sign_a, sign_b, b_zero, div_ovf, special;
  logic [DW-1:0] mag_a, mag_b;
  logic [DW:0]   add_sum, div_shift, div_diff;
  logic [PW-1:0] prod, prod_fix;
  logic [DW-1:0] quo_fix, rem_fix, fin_val;

  // Operand decode at the request boundary
  always_comb begin
    is_div_in = bus.op[2];
    a_signed  = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                (bus.op == OP_DIV)  || (bus.op == OP_REM);
    b_signed  = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    sign_a    = a_signed & bus.src_a[DW-1];
    sign_b    = b_signed & bus.src_b[DW-1];
    mag_a     = sign_a ? DW'(-bus.src_a) : bus.src_a;
    mag_b     = sign_b ? DW'(-bus.src_b) : bus.src_b;
    b_zero    = (bus.src_b == '0);
    div_ovf   = b_signed && (bus.src_a == {1'b1, {(DW-1){1'b0}}}) && (bus.src_b == '1);
    special   = is_div_in && (b_zero || div_ovf);
    accept_c  = (state_q == S_IDLE) && bus.start && !bus.flush && !done_q;
`ifdef MULDIV_FAST_MUL_EN
    direct_c  = special || !is_div_in;
`else
    direct_c  = special;
`endif
  end

  // Iteration step and final sign correction
  always_comb begin
    add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[DW-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    prod      = {hi_q, lo_q};
    prod_fix  = neg_q ? PW'(-prod) : prod;
    quo_fix   = neg_q ? DW'(-lo_q) : lo_q;
    rem_fix   = neg_q ? DW'(-hi_q) : hi_q;
    case (op_q)
      OP_DIV, OP_DIVU: fin_val = quo_fix;
      OP_REM, OP_REMU: fin_val = rem_fix;
      OP_MUL:          fin_val = prod_fix[DW-1:0];
      default:         fin_val = prod_fix[PW-1:DW];
    endcase
  end

  // Datapath registers; special cases preload hi/lo so the final mux yields the fixed answer
  always_comb begin
    op_d   = op_q;
    neg_d  = neg_q;
    opnd_d = opnd_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    cnt_d  = cnt_q;
    if (bus.flush) begin
      cnt_d = '0;
    end else if (accept_c) begin
      op_d  = bus.op;
      cnt_d = CNT_WIDTH'(DW);
      if (is_div_in) begin
        neg_d  = bus.op[1] ? sign_a : (sign_a ^ sign_b);
        opnd_d = mag_b;
        hi_d   = '0;
        lo_d   = mag_a;
        if (b_zero) begin
          neg_d = 1'b0;
          hi_d  = bus.src_a;
          lo_d  = '1;
        end else if (div_ovf) begin
          neg_d = 1'b0;
          hi_d  = '0;
          lo_d  = bus.src_a;
        end
      end else begin
        neg_d  = sign_a ^ sign_b;
        opnd_d = mag_a;
        hi_d   = '0;
        lo_d   = mag_b;
`ifdef MULDIV_FAST_MUL_EN
        {hi_d, lo_d} = PW'(mag_a) * PW'(mag_b);
`endif
      end
    end else if (state_q == S_CALC) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
      if (op_q[2]) begin
        if (!div_diff[DW]) begin
          hi_d = div_diff[DW-1:0];
          lo_d = {lo_q[DW-2:0], 1'b1};
        end else begin
          hi_d = div_shift[DW-1:0];
          lo_d = {lo_q[DW-2:0], 1'b0};
        end
      end else begin
        hi_d = add_sum[DW:1];
        lo_d = {add_sum[0], lo_q[DW-1:1]};
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (accept_c) state_d = direct_c ? S_FINISH : S_CALC;
        S_CALC:   if (cnt_q == CNT_WIDTH'(1)) state_d = S_FINISH;
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Registered handshake outputs
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_q == S_FINISH) && !bus.flush;
    result_d = done_d ? fin_val : result_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: arithmetic, special cases, latency, flush and reset.
module tb_muldiv_unit;
  localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  muldiv_unit_if #(.DATA_WIDTH(W)) bus_if ();
  muldiv_unit #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus_if.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.src_a = a;
    bus_if.src_b = b;
    tick();
    bus_if.start = 1'b0;
    bus_if.op    = ~op;
    bus_if.src_a = 32'h1234_5678;
    bus_if.src_b = 32'h0000_0003;
  endtask

  // Waits for done; drives start high for cycles lo..hi of the wait
  task automatic wait_done(input int lo, input int hi, output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      bus_if.start = (i >= lo) && (i <= hi);
      tick();
      if (bus_if.done === 1'b1) begin
        lat = i;
        break;
      end
      busy_ok = busy_ok && (bus_if.busy === 1'b1);
    end
    bus_if.start = 1'b0;
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    bit ok;
    start_op(op, a, b);
    wait_done(0, -1, lat, ok);
    check({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "/res"}, bus_if.result, exp);
    check({tag, "/busy"}, 32'(ok), 32'd1);
    check({tag, "/idle"}, 32'(bus_if.busy), 32'd0);
    tick();
    check({tag, "/pulse"}, 32'(bus_if.done), 32'd0);
  endtask

  initial begin
    int lat;
    bit ok;
    bit seen;

    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.flush = 1'b0;
    bus_if.op    = 3'b000;
    bus_if.src_a = '0;
    bus_if.src_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("idle%0d/busy", i), 32'(bus_if.busy), 32'd0);
      check($sformatf("idle%0d/done", i), 32'(bus_if.done), 32'd0);
      check($sformatf("idle%0d/res", i), bus_if.result, 32'd0);
    end

    run("mul",      3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run("mulh_m1",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
    run("div",      3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
    run("rem",      3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
    run("divu",     3'b101, 32'd100,       32'd7,         32'd14,        DIV_LAT);
    run("remu",     3'b111, 32'd100,       32'd7,         32'd2,         DIV_LAT);

    // Flush at cycle 10 of a divide: squashed, previous result retained
    start_op(3'b101, 32'd1000, 32'd3);
    for (int i = 1; i <= 9; i++) tick();
    check("flush/pre_busy", 32'(bus_if.busy), 32'd1);
    bus_if.flush = 1'b1;
    tick();
    check("flush/busy", 32'(bus_if.busy), 32'd0);
    check("flush/done", 32'(bus_if.done), 32'd0);
    check("flush/res", bus_if.result, 32'd2);
    bus_if.flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) seen = 1'b1;
    end
    check("flush/quiet", 32'(seen), 32'd0);

    // Start pulses during a busy divide must be ignored
    start_op(3'b101, 32'd100, 32'd7);
    bus_if.op    = 3'b000;
    bus_if.src_a = 32'd3;
    bus_if.src_b = 32'd3;
    wait_done(3, 20, lat, ok);
    check("ign/lat", 32'(lat), 32'(DIV_LAT));
    check("ign/res", bus_if.result, 32'd14);
    check("ign/busy", 32'(ok), 32'd1);
    repeat (3) tick();
    check("ign/idle", 32'(bus_if.busy), 32'd0);
    check("ign/res_hold", bus_if.result, 32'd14);

    run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run("remu_z",  3'b111, 32'd5,         32'd0,         32'd5,         1);
    run("div_z",   3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run("rem_z",   3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);

    // Reset at cycle 15 of a divide
    start_op(3'b100, 32'd100, 32'd7);
    for (int i = 1; i <= 14; i++) tick();
    check("rst/pre_busy", 32'(bus_if.busy), 32'd1);
    rst = 1'b1;
    tick();
    check("rst/busy", 32'(bus_if.busy), 32'd0);
    check("rst/done", 32'(bus_if.done), 32'd0);
    check("rst/res", bus_if.result, 32'd0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) seen = 1'b1;
    end
    check("rst/quiet", 32'(seen), 32'd0);

    run("mulhsu", 3'b010, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, MUL_LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
